key_debounce_scan: RTL and testbench

//  Input-side companion to the LED output blocks: samples NUM_KEYS active-low board push-buttons on the 12 MHz clock.

---
 rtl/key_debounce_scan_if.sv | 13 +
 rtl/key_debounce_scan.sv | 158 +++++++++++++++
 tb/tb_key_debounce_scan.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_scan_if.sv
// Key channel bundle: raw active-low buttons in, debounced level and edge pulses out.
// The slave modport is the debouncer; the master modport is the button/consumer side.
interface key_debounce_scan_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (output key_n, input key_level, input key_press, input key_release);
    modport slave  (input key_n, output key_level, output key_press, output key_release);
endinterface

// File: rtl/key_debounce_scan.sv
// Per-key synchroniser, debounce FSM and press/release pulse generator for active-low buttons.
// Optional auto-repeat of key_press while a key is held: define KEY_REPEAT_EN.
module key_debounce_scan #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_debounce_scan_if.slave    kif
);
    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] level_vec_s;
    logic [NUM_KEYS-1:0] press_vec_s;
    logic [NUM_KEYS-1:0] release_vec_s;

    // Two-flop synchroniser; resets to released so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= kif.key_n;
            sync2_r <= sync1_r;
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        state_t           state_r, state_s;
        logic [CNT_W-1:0] cnt_r, cnt_s;
        logic             level_r, level_s;
        logic             press_r, press_s;
        logic             release_r, release_s;
`ifdef KEY_REPEAT_EN
        logic             rep_r, rep_s;
`endif

        // Per-key state, counter and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r   <= IDLE;
                cnt_r     <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_r     <= 1'b0;
`endif
            end else begin
                state_r   <= state_s;
                cnt_r     <= cnt_s;
                level_r   <= level_s;
                press_r   <= press_s;
                release_r <= release_s;
`ifdef KEY_REPEAT_EN
                rep_r     <= rep_s;
`endif
            end
        end

        // Debounce next-state logic; counters are cleared or held by state, never wrap.
        always_comb begin
            state_s   = state_r;
            cnt_s     = cnt_r;
            level_s   = level_r;
            press_s   = 1'b0;
            release_s = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_s     = rep_r;
`endif
            case (state_r)
                IDLE: begin
                    cnt_s = '0;
                    if (!sync2_r[gi]) begin
                        state_s = PRESS_WAIT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_r[gi]) begin
                        state_s = IDLE;
                        cnt_s   = '0;
                    end else if (cnt_r == DEB_LAST) begin
                        state_s = PRESSED;
                        press_s = 1'b1;
                        level_s = 1'b1;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync2_r[gi]) begin
                        state_s = RELEASE_WAIT;
                        cnt_s   = '0;
`ifdef KEY_REPEAT_EN
                        rep_s   = 1'b0;
`endif
                    end else begin
`ifdef KEY_REPEAT_EN
                        // First repeat after the long delay, then at the shorter period.
                        if ((!rep_r && cnt_r == RPT_DELAY_LAST) ||
                            (rep_r && cnt_r == RPT_PERIOD_LAST)) begin
                            press_s = 1'b1;
                            cnt_s   = '0;
                            rep_s   = 1'b1;
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
`else
                        cnt_s = '0;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_r[gi]) begin
                        state_s = PRESSED;
                        cnt_s   = '0;
                    end else if (cnt_r == DEB_LAST) begin
                        state_s   = IDLE;
                        release_s = 1'b1;
                        level_s   = 1'b0;
                        cnt_s     = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    level_s = 1'b0;
                end
            endcase
        end

        assign level_vec_s[gi]   = level_r;
        assign press_vec_s[gi]   = press_r;
        assign release_vec_s[gi] = release_r;
    end

    assign kif.key_level   = level_vec_s;
    assign kif.key_press   = press_vec_s;
    assign kif.key_release = release_vec_s;
endmodule

// File: tb/tb_key_debounce_scan.sv
// Scoreboard bench for key_debounce_scan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
// Expected pulses are queued when keys are driven and matched when the DUT pulses.
module tb_key_debounce_scan;
    localparam int NK = 4;

    typedef struct {
        int         t;
        logic [3:0] p;
        logic [3:0] r;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  sb[$];
    ev_t  ev_mon;

    key_debounce_scan_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_scan #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kif(kif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int t, input logic [3:0] p, input logic [3:0] r);
        ev_t e;
        e.t = t;
        e.p = p;
        e.r = r;
        sb.push_back(e);
    endtask

    // Drive key_n on a falling edge; k is the rising edge that first samples it.
    task automatic drive(input logic [3:0] kn, output int k);
        @(negedge clk);
        kif.key_n = kn;
        k = cyc + 1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && ((kif.key_press | kif.key_release) != 4'b0000)) begin
            check_eq("press_release_excl", {28'd0, kif.key_press & kif.key_release}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("spurious_pulse", {24'd0, kif.key_press, kif.key_release}, 32'd0);
            end else begin
                ev_mon = sb.pop_front();
                check_eq("pulse_time", cyc, ev_mon.t);
                check_eq("press_mask", {28'd0, kif.key_press}, {28'd0, ev_mon.p});
                check_eq("release_mask", {28'd0, kif.key_release}, {28'd0, ev_mon.r});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        kif.key_n = 4'b1111;
        rst_n     = 1'b0;
        hold(3);
        check_eq("reset_level", {28'd0, kif.key_level}, 32'd0);
        check_eq("reset_press", {28'd0, kif.key_press}, 32'd0);
        check_eq("reset_release", {28'd0, kif.key_release}, 32'd0);
        rst_n = 1'b1;
        hold(5);
        check_eq("idle_level", {28'd0, kif.key_level}, 32'd0);

        // Clean press of key 0, released before any repeat could fire.
        drive(4'b1110, k);
        push_ev(k + 10, 4'b0001, 4'b0000);
        hold(25);
        check_eq("t1_level", {28'd0, kif.key_level}, 32'd1);

        // Clean release of key 0.
        drive(4'b1111, k);
        push_ev(k + 10, 4'b0000, 4'b0001);
        hold(15);
        check_eq("t3_level_rel", {28'd0, kif.key_level}, 32'd0);

        // Press again, then release with bounce: only the final rise counts.
        drive(4'b1110, k);
        push_ev(k + 10, 4'b0001, 4'b0000);
        hold(15);
        drive(4'b1111, k);
        hold(3);
        drive(4'b1110, k);
        hold(1);
        check_eq("t3_level_bounce", {28'd0, kif.key_level}, 32'd1);
        drive(4'b1111, k);
        push_ev(k + 10, 4'b0000, 4'b0001);
        hold(15);
        check_eq("t3_level_final", {28'd0, kif.key_level}, 32'd0);

        // Press bounce on key 1: never accepted.
        drive(4'b1101, k);
        hold(4);
        drive(4'b1111, k);
        hold(2);
        drive(4'b1101, k);
        hold(3);
        drive(4'b1111, k);
        hold(12);
        check_eq("t2_level", {28'd0, kif.key_level}, 32'd0);

        // Keys 0 and 3 pressed on the same edge.
        drive(4'b0110, k);
        push_ev(k + 10, 4'b1001, 4'b0000);
        hold(15);
        check_eq("t4_level", {28'd0, kif.key_level}, 32'h9);

        // Key 1 joins; reset mid-debounce with keys held low.
        drive(4'b0100, k);
        hold(8);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_level", {28'd0, kif.key_level}, 32'd0);
        check_eq("t5_rst_press", {28'd0, kif.key_press}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc + 1;
        push_ev(k + 10, 4'b1011, 4'b0000);
        hold(9);
        check_eq("t5_level_early", {28'd0, kif.key_level}, 32'd0);
        hold(6);
        check_eq("t5_level", {28'd0, kif.key_level}, 32'hB);
        drive(4'b1111, k);
        push_ev(k + 10, 4'b0000, 4'b1011);
        hold(15);
        check_eq("t5_level_rel", {28'd0, kif.key_level}, 32'd0);

        // Long hold of key 2: auto-repeat only when enabled.
        drive(4'b1011, k);
        push_ev(k + 10, 4'b0100, 4'b0000);
`ifdef KEY_REPEAT_EN
        for (int t = 30; t <= 61; t += 5) push_ev(k + t, 4'b0100, 4'b0000);
`endif
        hold(60);
        check_eq("t6_level", {28'd0, kif.key_level}, 32'h4);
        drive(4'b1111, k);
        push_ev(k + 10, 4'b0000, 4'b0100);
        hold(20);
        check_eq("t6_level_rel", {28'd0, kif.key_level}, 32'd0);

        check_eq("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
